// File: rtl/dht11_frame_tx.sv
// dht11_frame_tx: paces DHT11 sample requests, latches each reading and streams it
// to the UART transmitter as the 13-byte ASCII line "T=ddd H=ddd\r\n".
`timescale 1ns/1ps

module dht11_frame_tx #(
    parameter int unsigned SAMPLE_PERIOD = 100000000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_rdy,
    input  logic [7:0] temperature,
    input  logic [7:0] humidity,
    input  logic       TxD_busy,
    output logic       sample_en,
    output logic       TxD_start,
    output logic [7:0] TxD_data,
    output logic       frame_busy
);

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StSend,
        StWaitHi,
        StWaitLo
    } state_e;

    // Conversion phases inside StConv.
    typedef enum logic [1:0] {
        ConvLoad,
        ConvTemp,
        ConvHum
    } conv_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [3:0]       LastIdx = 4'd12;

    state_e           state_q, state_d;
    conv_e            conv_q, conv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             wrap;
    logic [7:0]       t_reg_q, t_reg_d;
    logic [7:0]       h_reg_q, h_reg_d;
    logic [7:0]       rem_q, rem_d;
    logic [3:0]       hun_q, hun_d;
    logic [3:0]       ten_q, ten_d;
    logic [3:0]       t_hun_q, t_hun_d;
    logic [3:0]       t_ten_q, t_ten_d;
    logic [3:0]       t_one_q, t_one_d;
    logic [3:0]       h_hun_q, h_hun_d;
    logic [3:0]       h_ten_q, h_ten_d;
    logic [3:0]       h_one_q, h_one_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       idx_nxt;
    logic [7:0]       next_byte;
    logic [7:0]       txd_data_q, txd_data_d;
    logic             frame_busy_q, frame_busy_d;

    // Sample timer: free-running wrap counter; a wrap is remembered until the FSM is idle.
    always_comb begin
        wrap      = (cnt_q == CntLast);
        cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
        sample_en = pending_q && (state_q == StIdle);
        pending_d = pending_q;
        if (sample_en) begin
            pending_d = 1'b0;
        end
        // A wrap in the same cycle as a pulse is a new period and must not be lost.
        if (wrap) begin
            pending_d = 1'b1;
        end
    end

    // Byte that follows the current index in the output line.
    always_comb begin
        idx_nxt = idx_q + 4'd1;
        case (idx_nxt)
            4'd0:    next_byte = 8'h54;
            4'd1:    next_byte = 8'h3D;
            4'd2:    next_byte = {4'h3, t_hun_q};
            4'd3:    next_byte = {4'h3, t_ten_q};
            4'd4:    next_byte = {4'h3, t_one_q};
            4'd5:    next_byte = 8'h20;
            4'd6:    next_byte = 8'h48;
            4'd7:    next_byte = 8'h3D;
            4'd8:    next_byte = {4'h3, h_hun_q};
            4'd9:    next_byte = {4'h3, h_ten_q};
            4'd10:   next_byte = {4'h3, h_one_q};
            4'd11:   next_byte = 8'h0D;
            4'd12:   next_byte = 8'h0A;
            default: next_byte = 8'h00;
        endcase
    end

    // Frame FSM next-state: latch, convert to BCD by repeated subtraction, then send bytes.
    always_comb begin
        state_d      = state_q;
        conv_d       = conv_q;
        t_reg_d      = t_reg_q;
        h_reg_d      = h_reg_q;
        rem_d        = rem_q;
        hun_d        = hun_q;
        ten_d        = ten_q;
        t_hun_d      = t_hun_q;
        t_ten_d      = t_ten_q;
        t_one_d      = t_one_q;
        h_hun_d      = h_hun_q;
        h_ten_d      = h_ten_q;
        h_one_d      = h_one_q;
        idx_d        = idx_q;
        txd_data_d   = txd_data_q;
        frame_busy_d = frame_busy_q;

        unique case (state_q)
            StIdle: begin
                if (data_rdy) begin
                    t_reg_d      = temperature;
                    h_reg_d      = humidity;
                    conv_d       = ConvLoad;
                    frame_busy_d = 1'b1;
                    state_d      = StConv;
                end
            end
            StConv: begin
                if (conv_q == ConvLoad) begin
                    rem_d  = t_reg_q;
                    hun_d  = 4'd0;
                    ten_d  = 4'd0;
                    conv_d = ConvTemp;
                end else if (rem_q >= 8'd100) begin
                    rem_d = rem_q - 8'd100;
                    hun_d = hun_q + 4'd1;
                end else if (rem_q >= 8'd10) begin
                    rem_d = rem_q - 8'd10;
                    ten_d = ten_q + 4'd1;
                end else if (conv_q == ConvTemp) begin
                    t_hun_d = hun_q;
                    t_ten_d = ten_q;
                    t_one_d = rem_q[3:0];
                    rem_d   = h_reg_q;
                    hun_d   = 4'd0;
                    ten_d   = 4'd0;
                    conv_d  = ConvHum;
                end else begin
                    h_hun_d    = hun_q;
                    h_ten_d    = ten_q;
                    h_one_d    = rem_q[3:0];
                    idx_d      = 4'd0;
                    txd_data_d = 8'h54;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (!TxD_busy) begin
                    state_d = StWaitHi;
                end
            end
            StWaitHi: begin
                // Guard cycle so the transmitter has time to raise busy.
                state_d = StWaitLo;
            end
            StWaitLo: begin
                if (!TxD_busy) begin
                    if (idx_q == LastIdx) begin
                        frame_busy_d = 1'b0;
                        state_d      = StIdle;
                    end else begin
                        idx_d      = idx_nxt;
                        txd_data_d = next_byte;
                        state_d    = StSend;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Start strobe only while the byte is presented and the transmitter is free.
    always_comb begin
        TxD_start  = (state_q == StSend) && !TxD_busy;
        TxD_data   = txd_data_q;
        frame_busy = frame_busy_q;
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            conv_q       <= ConvLoad;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            t_reg_q      <= 8'h00;
            h_reg_q      <= 8'h00;
            rem_q        <= 8'h00;
            hun_q        <= 4'd0;
            ten_q        <= 4'd0;
            t_hun_q      <= 4'd0;
            t_ten_q      <= 4'd0;
            t_one_q      <= 4'd0;
            h_hun_q      <= 4'd0;
            h_ten_q      <= 4'd0;
            h_one_q      <= 4'd0;
            idx_q        <= 4'd0;
            txd_data_q   <= 8'h00;
            frame_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            conv_q       <= conv_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            t_reg_q      <= t_reg_d;
            h_reg_q      <= h_reg_d;
            rem_q        <= rem_d;
            hun_q        <= hun_d;
            ten_q        <= ten_d;
            t_hun_q      <= t_hun_d;
            t_ten_q      <= t_ten_d;
            t_one_q      <= t_one_d;
            h_hun_q      <= h_hun_d;
            h_ten_q      <= h_ten_d;
            h_one_q      <= h_one_d;
            idx_q        <= idx_d;
            txd_data_q   <= txd_data_d;
            frame_busy_q <= frame_busy_d;
        end
    end

endmodule

// File: tb/tb_dht11_frame_tx.sv
// Scoreboard bench for dht11_frame_tx: expected bytes are queued when a reading is
// issued; a monitor pops and compares on every TxD_start.
`timescale 1ns/1ps

module tb_dht11_frame_tx;

    localparam int unsigned SP = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_rdy = 1'b0;
    logic [7:0] temperature = 8'h00;
    logic [7:0] humidity = 8'h00;
    logic       TxD_busy = 1'b0;
    logic       sample_en;
    logic       TxD_start;
    logic [7:0] TxD_data;
    logic       frame_busy;

    dht11_frame_tx #(
        .SAMPLE_PERIOD(SP),
        .CNT_W        (27)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_rdy   (data_rdy),
        .temperature(temperature),
        .humidity   (humidity),
        .TxD_busy   (TxD_busy),
        .sample_en  (sample_en),
        .TxD_start  (TxD_start),
        .TxD_data   (TxD_data),
        .frame_busy (frame_busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int         bytes_seen = 0;
    int         se_count = 0;
    int         busy_len = 4;
    bit         uart_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the line the spec prescribes, built with plain decimal arithmetic.
    function automatic void push_frame(input int t, input int h);
        exp_q.push_back(8'h54);
        exp_q.push_back(8'h3D);
        exp_q.push_back(8'(48 + t / 100));
        exp_q.push_back(8'(48 + (t / 10) % 10));
        exp_q.push_back(8'(48 + t % 10));
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h3D);
        exp_q.push_back(8'(48 + h / 100));
        exp_q.push_back(8'(48 + (h / 10) % 10));
        exp_q.push_back(8'(48 + h % 10));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // Monitor: every start strobe must match the next queued byte inside a busy frame.
    always @(negedge clk) begin
        if (sample_en === 1'b1) se_count++;
        if (TxD_start === 1'b1) begin
            bytes_seen++;
            check("txd_start_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("txd_data", 32'(TxD_data), 32'(mon_exp));
            end
            check("frame_busy_during_byte", 32'(frame_busy), 32'd1);
        end
    end

    // UART model: busy rises just after the edge that takes the start, lasts busy_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (TxD_start === 1'b1) begin
                uart_active = 1'b1;
                @(posedge clk);
                #1 TxD_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 TxD_busy = 1'b0;
                uart_active = 1'b0;
            end
        end
    end

    task automatic issue_rdy(input int t, input int h, input bit expect_frame);
        if (expect_frame) push_frame(t, h);
        @(posedge clk);
        #1;
        data_rdy    = 1'b1;
        temperature = 8'(t);
        humidity    = 8'(h);
        @(posedge clk);
        #1;
        data_rdy    = 1'b0;
        temperature = 8'($urandom);
        humidity    = 8'($urandom);
    endtask

    // Returns in the first idle cycle (posedge + 2 ns) after the last byte's busy falls.
    task automatic wait_frame_end(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 4000 && !done; k++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && !uart_active) done = 1'b1;
        end
        check({name, "_frame_done"}, 32'(done), 32'd1);
        if (!done) begin
            exp_q.delete();
        end else begin
            check({name, "_frame_busy_last_wait"}, 32'(frame_busy), 32'd1);
            @(posedge clk);
            #2;
            check({name, "_frame_busy_idle"}, 32'(frame_busy), 32'd0);
        end
    endtask

    task automatic wait_bytes(input int target);
        bit done = 1'b0;
        for (int k = 0; k < 4000 && !done; k++) begin
            @(posedge clk);
            #2;
            if (bytes_seen >= target) done = 1'b1;
        end
        check("wait_bytes_reached", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int t;
        int h;
    } reading_t;

    reading_t corners[5] = '{'{0, 0}, '{255, 99}, '{100, 10}, '{199, 199}, '{9, 255}};

    initial begin
        int se0;
        int b0;
        int t;
        int h;

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check("rst_sample_en", 32'(sample_en), 32'd0);
        check("rst_txd_start", 32'(TxD_start), 32'd0);
        check("rst_txd_data", 32'(TxD_data), 32'd0);
        check("rst_frame_busy", 32'(frame_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Timer only: pulses at 100, 200, 300 edges after release
        for (int n = 1; n <= 350; n++) begin
            @(posedge clk);
            #2;
            check("sample_en_timer", 32'(sample_en), 32'(n % SP == 0));
        end

        // Nominal 25/60 frame spanning several wraps: sample_en deferred to first idle cycle
        do_reset();
        busy_len = 18;
        repeat (88) @(posedge clk);
        se0 = se_count;
        issue_rdy(25, 60, 1'b1);
        wait_frame_end("nominal");
        check("no_sample_en_in_frame", 32'(se_count), 32'(se0));
        check("deferred_sample_en_first_idle", 32'(sample_en), 32'd1);
        @(posedge clk);
        #2;
        check("deferred_sample_en_single", 32'(sample_en), 32'd0);

        // Digit extremes
        foreach (corners[i]) begin
            busy_len = int'($urandom_range(1, 6));
            issue_rdy(corners[i].t, corners[i].h, 1'b1);
            wait_frame_end("corner");
        end

        // Random readings, with a stray data_rdy landing somewhere inside the frame
        for (int i = 0; i < 8; i++) begin
            busy_len = int'($urandom_range(1, 8));
            t = int'($urandom_range(0, 255));
            h = int'($urandom_range(0, 255));
            issue_rdy(t, h, 1'b1);
            repeat ($urandom_range(0, 30)) @(posedge clk);
            issue_rdy(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
            wait_frame_end("random");
        end

        // Overlap: second reading during byte 5 is ignored, no second frame follows
        busy_len = 5;
        b0 = bytes_seen;
        issue_rdy(25, 60, 1'b1);
        wait_bytes(b0 + 6);
        issue_rdy(30, 70, 1'b0);
        wait_frame_end("overlap");
        repeat (60) @(posedge clk);
        issue_rdy(30, 70, 1'b1);
        wait_frame_end("after_overlap");

        // Asynchronous reset during byte 7, not aligned to the clock
        busy_len = 6;
        b0 = bytes_seen;
        issue_rdy(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);
        wait_bytes(b0 + 8);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_sample_en", 32'(sample_en), 32'd0);
        check("midrst_txd_start", 32'(TxD_start), 32'd0);
        check("midrst_txd_data", 32'(TxD_data), 32'd0);
        check("midrst_frame_busy", 32'(frame_busy), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (80) @(posedge clk);
        busy_len = 3;
        issue_rdy(7, 42, 1'b1);
        wait_frame_end("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
